// File: rtl/cpu_debug_ctrl.sv
// Debug controller: boots the CPU, gates its clock for run/step,
// and streams pc, inst, register file and a memory window out on request.
module cpu_debug_ctrl #(
  parameter int          NREG       = 32,
  parameter int          MEM_WORDS  = 16,
  parameter logic [31:0] MEM_BASE   = 32'h0,
  parameter int          RESET_HOLD = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic        cpu_resetn,
  output logic        cpu_clk_en,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    BOOT, IDLE, RUN, STEP, DUMP
  } state_e;

  localparam logic [8:0]  RF_END    = 9'(2 + NREG);
  localparam logic [8:0]  LAST_BEAT = 9'(1 + NREG + MEM_WORDS);
  localparam logic [31:0] HOLD_MAX  = 32'(RESET_HOLD - 1);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] step_q, step_d;
  logic [8:0]  beat_q, beat_d;
  logic        phase_q, phase_d;
  logic        resetn_q, resetn_d;
  logic        clk_en_q, clk_en_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] mem_off;
  logic        acc;

  assign acc = cmd_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    step_d     = step_q;
    beat_d     = beat_q;
    phase_d    = phase_q;
    resetn_d   = resetn_q;
    clk_en_d   = clk_en_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    rf_addr_d  = '0;
    mem_addr_d = MEM_BASE;
    mem_off    = '0;
    cycle_d    = cycle_q + {31'd0, clk_en_q};

    unique case (state_q)
      BOOT: begin
        resetn_d = 1'b0;
        clk_en_d = 1'b0;
        ready_d  = 1'b0;
        hold_d   = hold_q + 32'd1;
        if (hold_q == HOLD_MAX) begin
          state_d  = IDLE;
          resetn_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      IDLE: begin
        ready_d  = 1'b1;
        clk_en_d = 1'b0;
        if (acc) begin
          if (cmd_op == OP_RUN) begin
            state_d  = RUN;
            clk_en_d = 1'b1;
          end else if (cmd_op == OP_STEP && cmd_arg != 16'd0) begin
            state_d  = STEP;
            step_d   = cmd_arg;
            clk_en_d = 1'b1;
            ready_d  = 1'b0;
          end else if (cmd_op == OP_DUMP) begin
            state_d = DUMP;
            ready_d = 1'b0;
            beat_d  = '0;
            phase_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (acc && cmd_op == OP_HALT) begin
          state_d  = IDLE;
          clk_en_d = 1'b0;
        end
      end
      STEP: begin
        step_d = step_q - 16'd1;
        if (step_q == 16'd1) begin
          state_d  = IDLE;
          clk_en_d = 1'b0;
          ready_d  = 1'b1;
        end
      end
      DUMP: begin
        if (!phase_q) begin
          // address settled during the setup cycle; capture now
          phase_d = 1'b1;
          valid_d = 1'b1;
          last_d  = (beat_q == LAST_BEAT);
          if (beat_q == 9'd0)
            data_d = cpu_pc;
          else if (beat_q == 9'd1)
            data_d = cpu_inst;
          else if (beat_q < RF_END)
            data_d = rf_data;
          else
            data_d = mem_data;
        end else if (dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            beat_d  = beat_q + 9'd1;
            phase_d = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (state_d == DUMP) begin
      if (beat_d >= 9'd2 && beat_d < RF_END)
        rf_addr_d = 5'(beat_d - 9'd2);
      if (beat_d >= RF_END) begin
        mem_off    = 32'(beat_d - RF_END);
        mem_addr_d = MEM_BASE + (mem_off << 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      hold_q     <= '0;
      step_q     <= '0;
      beat_q     <= '0;
      phase_q    <= 1'b0;
      resetn_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      rf_addr_q  <= '0;
      mem_addr_q <= MEM_BASE;
      cycle_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      step_q     <= step_d;
      beat_q     <= beat_d;
      phase_q    <= phase_d;
      resetn_q   <= resetn_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rf_addr_q  <= rf_addr_d;
      mem_addr_q <= mem_addr_d;
      cycle_q    <= cycle_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign cpu_resetn  = resetn_q;
  assign cpu_clk_en  = clk_en_q;
  assign rf_addr     = rf_addr_q;
  assign mem_addr    = mem_addr_q;
  assign dump_valid  = valid_q;
  assign dump_data   = data_q;
  assign dump_last   = last_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl: boot hold, step, run/halt,
// dump with and without backpressure, reset in the middle of a dump.
module tb_cpu_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_arg = 16'd0;
  logic        cpu_resetn;
  logic        cpu_clk_en;
  logic [31:0] cpu_pc = 32'h1234_5678;
  logic [31:0] cpu_inst = 32'h0000_0013;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_data;
  logic        dump_last;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int dv_cnt = 0;

  assign rf_data  = 32'hA000_0000 + {27'd0, rf_addr};
  assign mem_data = 32'hB000_0000 ^ mem_addr;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_clk_en === 1'b1) en_cnt++;
    if (dump_valid === 1'b1) dv_cnt++;
  end

  cpu_debug_ctrl #(
    .NREG(4), .MEM_WORDS(2),
    .MEM_BASE(32'h100), .RESET_HOLD(10)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cpu_resetn(cpu_resetn), .cpu_clk_en(cpu_clk_en),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input logic [1:0] op,
                          input logic [15:0] arg);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_arg = 16'hFFFF;
    chk({tag, "_accepted"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic boot_lows(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (cpu_resetn === 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_hold"}, 32'(n), 32'd10);
    chk({tag, "_resetn"}, {31'd0, cpu_resetn}, 32'd1);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  logic [31:0] exp1 [8];
  logic [31:0] got [16];
  logic        gl [16];
  int e0, d0, nb;
  bit done, held, hl, hit;
  logic [31:0] hd;

  initial begin
    exp1 = '{32'h1234_5678, 32'h0000_0013,
             32'hA000_0000, 32'hA000_0001,
             32'hA000_0002, 32'hA000_0003,
             32'hB000_0100, 32'hB000_0104};

    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_resetn", {31'd0, cpu_resetn}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_dv", {31'd0, dump_valid}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h100);
    // the initial negedge is already counted as a low cycle below
    begin : first_boot
      int n;
      n = 0;
      while (cpu_resetn === 1'b0 && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("boot_hold", 32'(n), 32'd10);
      chk("boot_ready", {31'd0, cmd_ready}, 32'd1);
    end

    e0 = en_cnt;
    send_cmd("step5", 2'b01, 16'd5);
    @(negedge clk);
    chk("step5_ready_low", {31'd0, cmd_ready}, 32'd0);
    chk("step5_en_high", {31'd0, cpu_clk_en}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("step5_en_cycles", 32'(en_cnt - e0), 32'd5);
    chk("step5_count", cycle_count, 32'd5);
    chk("step5_idle", {31'd0, cmd_ready}, 32'd1);

    e0 = en_cnt;
    send_cmd("step0", 2'b01, 16'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("step0_en_cycles", 32'(en_cnt - e0), 32'd0);
    chk("step0_count", cycle_count, 32'd5);
    chk("step0_ready", {31'd0, cmd_ready}, 32'd1);

    e0 = en_cnt;
    d0 = dv_cnt;
    send_cmd("run", 2'b00, 16'd0);
    send_cmd("run_dump", 2'b11, 16'd0);
    repeat (18) @(posedge clk);
    #1;
    send_cmd("halt", 2'b10, 16'd0);
    @(negedge clk);
    chk("halt_en_low", {31'd0, cpu_clk_en}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_en_cycles", 32'(en_cnt - e0), 32'd20);
    chk("run_count", cycle_count, 32'd25);
    chk("run_no_dump", 32'(dv_cnt - d0), 32'd0);
    chk("halt_ready", {31'd0, cmd_ready}, 32'd1);

    dump_ready = 1'b1;
    send_cmd("dump1", 2'b11, 16'd0);
    nb = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (dump_valid === 1'b1 && nb < 16) begin
        got[nb] = dump_data;
        gl[nb] = dump_last;
        nb++;
        if (dump_last === 1'b1) done = 1'b1;
      end
    end
    chk("dump1_done", {31'd0, done}, 32'd1);
    chk("dump1_beats", 32'(nb), 32'd8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk($sformatf("dump1_data%0d", i), got[i], exp1[i]);
      chk($sformatf("dump1_last%0d", i), {31'd0, gl[i]},
          (i == 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    chk("dump1_idle", {31'd0, cmd_ready}, 32'd1);
    chk("dump1_dv_low", {31'd0, dump_valid}, 32'd0);
    chk("dump1_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("dump1_mem_addr", mem_addr, 32'h100);

    cpu_pc = 32'hCAFE_0004;
    exp1[0] = 32'hCAFE_0004;
    dump_ready = 1'b0;
    send_cmd("dump2", 2'b11, 16'd0);
    nb = 0;
    done = 1'b0;
    held = 1'b0;
    hl = 1'b0;
    hd = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1 dump_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (held) begin
        chk("bp_valid", {31'd0, dump_valid}, 32'd1);
        chk("bp_data", dump_data, hd);
        chk("bp_last", {31'd0, dump_last}, {31'd0, hl});
      end
      held = 1'b0;
      if (dump_valid === 1'b1) begin
        if (dump_ready) begin
          if (nb < 16) begin
            got[nb] = dump_data;
            gl[nb] = dump_last;
          end
          nb++;
          if (dump_last === 1'b1) done = 1'b1;
        end else begin
          held = 1'b1;
          hd = dump_data;
          hl = dump_last;
        end
      end
    end
    chk("dump2_done", {31'd0, done}, 32'd1);
    chk("dump2_beats", 32'(nb), 32'd8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk($sformatf("dump2_data%0d", i), got[i], exp1[i]);
      chk($sformatf("dump2_last%0d", i), {31'd0, gl[i]},
          (i == 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    chk("dump2_idle", {31'd0, cmd_ready}, 32'd1);

    dump_ready = 1'b1;
    send_cmd("dump3", 2'b11, 16'd0);
    nb = 0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (dump_valid === 1'b1) begin
        nb++;
        if (nb == 3) hit = 1'b1;
      end
    end
    chk("dump3_hit", {31'd0, hit}, 32'd1);
    chk("dump3_beat3", dump_data, 32'hA000_0000);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_dv", {31'd0, dump_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, dump_last}, 32'd0);
    chk("mid_rst_data", dump_data, 32'd0);
    chk("mid_rst_resetn", {31'd0, cpu_resetn}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("mid_rst_cycles", cycle_count, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h100);

    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    boot_lows("reboot");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ctrl.md
CPU_DEBUG_CTRL -- requirements
Module: cpu_debug_ctrl

Interface
REQ-001 Parameter NREG, default 32, number of register-file words dumped (1..32).
REQ-002 Parameter MEM_WORDS, default 16, number of data-memory words dumped (1..256).
REQ-003 Parameter MEM_BASE, default 32'h0, byte address of first dumped memory word.
REQ-004 Parameter RESET_HOLD, default 10, cycles CPU reset is held after controller reset (>=1).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offer.
REQ-008 cmd_ready  out  1  command acceptance; transfer when cmd_valid & cmd_ready.
REQ-009 cmd_op  in  2  00 RUN, 01 STEP, 10 HALT, 11 DUMP.
REQ-010 cmd_arg  in  16  step count for STEP; ignored otherwise.
REQ-011 cpu_resetn  out  1  active-low reset to CPU.
REQ-012 cpu_clk_en  out  1  CPU clock enable; CPU advances one instruction per cycle it is high.
REQ-013 cpu_pc  in  32, cpu_inst  in  32  CPU current PC and instruction.
REQ-014 rf_addr  out  5, rf_data  in  32  register-file debug read port (combinational in CPU).
REQ-015 mem_addr  out  32, mem_data  in  32  data-memory debug read port (combinational in CPU).
REQ-016 dump_valid  out  1, dump_ready  in  1, dump_data  out  32, dump_last  out  1  dump stream.
REQ-017 cycle_count  out  32  count of cycles with cpu_clk_en high.

Function
REQ-018 States SHALL be BOOT, IDLE, RUN, STEP, DUMP; all outputs registered.
REQ-019 BOOT: cpu_resetn=0, cpu_clk_en=0, cmd_ready=0 for exactly RESET_HOLD cycles, then IDLE with cpu_resetn=1.
REQ-020 IDLE: cmd_ready=1, cpu_clk_en=0; RUN->RUN, STEP(arg>0)->STEP, DUMP->DUMP, HALT and STEP(arg=0) accepted as no-ops.
REQ-021 RUN: cpu_clk_en=1 from the cycle after acceptance; cmd_ready=1; HALT -> IDLE with cpu_clk_en=0 the cycle after acceptance; other ops accepted and dropped.
REQ-022 STEP: cpu_clk_en=1 for exactly cmd_arg consecutive cycles starting the cycle after acceptance, then IDLE; cmd_ready=0 in STEP.
REQ-023 DUMP: cmd_ready=0; emits 2+NREG+MEM_WORDS beats in order: cpu_pc, cpu_inst, rf[0..NREG-1], mem[MEM_BASE+4*i], i=0..MEM_WORDS-1.
REQ-024 Each beat: one setup cycle (address driven, dump_valid=0), then dump_data captured from input, dump_valid=1 until dump_ready sampled high.
REQ-025 dump_data and dump_last SHALL be stable while dump_valid=1 and dump_ready=0.
REQ-026 dump_last=1 only on final beat; after its handshake -> IDLE next cycle.
REQ-027 rf_addr and mem_addr SHALL be 0 and MEM_BASE outside DUMP.
REQ-028 cycle_count increments by 1 each cycle cpu_clk_en=1, wraps 32'hFFFFFFFF->0; not cleared by commands.
REQ-029 cmd_arg captured at acceptance; later changes ignored.

Reset
REQ-030 reset=1 at any clock edge, in any state (including mid-dump, mid-step) -> BOOT next cycle; cpu_resetn=0, cpu_clk_en=0, cmd_ready=0, dump_valid=0, dump_last=0, dump_data=0, cycle_count=0, rf_addr=0, mem_addr=MEM_BASE.
REQ-031 BOOT hold counter restarts on every reset cycle; hold counts from reset deassertion.

Verification
REQ-032 reset 1 cycle, RESET_HOLD=10 -> cpu_resetn low exactly 10 cycles after reset drops, cmd_ready rises same cycle cpu_resetn rises.
REQ-033 STEP arg=5 -> cpu_clk_en high exactly 5 cycles, cycle_count=5, IDLE; STEP arg=0 -> no enable, cycle_count unchanged.
REQ-034 RUN, HALT 20 cycles later -> cpu_clk_en high exactly 20 cycles, cycle_count=20; DUMP offered during RUN dropped (no dump_valid).
REQ-035 DUMP, NREG=4, MEM_WORDS=2, MEM_BASE=32'h100, dump_ready=1 -> 8 beats pc, inst, rf0..rf3, mem[0x100], mem[0x104]; dump_last only on 8th.
REQ-036 DUMP with dump_ready toggled randomly -> data/last stable under backpressure, no beat lost or duplicated.
REQ-037 reset asserted on beat 3 of dump -> dump_valid=0 next cycle, BOOT re-entered, cycle_count=0.
